// File: rtl/iddr_deser_pkg.sv
// Shared types and constants for the IDDR deserializer.
//   state_e    : slip FSM state (RUN, SLIP, GUARD)
//   GCNT_W     : guard counter width
//   MCNT_W     : training match counter width
//   width_ok() : legality check for the WIDTH parameter (even, 4..16)
package iddr_deser_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_SLIP  = 2'd1,
    ST_GUARD = 2'd2
  } state_e;

  localparam int GCNT_W = 4;
  localparam int MCNT_W = 4;

  function automatic bit width_ok(input int w);
    return (w >= 4) && (w <= 16) && ((w % 2) == 0);
  endfunction

endpackage

// File: rtl/iddr_deser_if.sv
// Bus bundle between the IDDRE1 capture stage / link layer and the deserializer.
//   EN, Q1, Q2    : sample enable and rising/falling-edge bit pair
//   BITSLIP       : single-cycle slip request
//   TRAIN         : link is sending the training word
//   DOUT, DVALID  : assembled word (MSB = earliest bit) and its strobe
//   SLIP_BUSY     : slip in progress or guard active
//   LOCKED        : auto-alignment achieved
interface iddr_deser_if #(parameter int WIDTH = 8);
  logic             EN;
  logic             Q1;
  logic             Q2;
  logic             BITSLIP;
  logic             TRAIN;
  logic [WIDTH-1:0] DOUT;
  logic             DVALID;
  logic             SLIP_BUSY;
  logic             LOCKED;

  modport master (output EN, Q1, Q2, BITSLIP, TRAIN,
                  input  DOUT, DVALID, SLIP_BUSY, LOCKED);
  modport slave  (input  EN, Q1, Q2, BITSLIP, TRAIN,
                  output DOUT, DVALID, SLIP_BUSY, LOCKED);
endinterface

// File: rtl/iddr_deser_align.sv
// Training-word comparator for auto-alignment (IDDR_DESER_AUTOALIGN_EN builds).
//   clk, rst_n   : clock, async active-low reset
//   word_stb_i   : a word is being emitted while the slip FSM is in RUN
//   word_i       : that word
//   train_i      : link is sending the training pattern
//   ext_slip_i   : accepted external BITSLIP (drops lock)
//   auto_slip_o  : request a slip, same cycle as the mismatching word
//   locked_o     : MATCH_COUNT consecutive matches seen
module iddr_deser_align
  import iddr_deser_pkg::*;
#(
  parameter int               WIDTH         = 8,
  parameter logic [WIDTH-1:0] TRAIN_PATTERN = WIDTH'(8'h5C),
  parameter int               MATCH_COUNT   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             word_stb_i,
  input  logic [WIDTH-1:0] word_i,
  input  logic             train_i,
  input  logic             ext_slip_i,
  output logic             auto_slip_o,
  output logic             locked_o
);

  logic [MCNT_W-1:0] mcnt_q, mcnt_d;
  logic              locked_q, locked_d;
  logic              check;

  // Once locked the comparator goes quiet; only reset or BITSLIP re-arms it.
  assign check       = word_stb_i && train_i && !locked_q;
  assign auto_slip_o = check && (word_i != TRAIN_PATTERN);
  assign locked_o    = locked_q;

  always_comb begin
    mcnt_d   = mcnt_q;
    locked_d = locked_q;
    if (ext_slip_i) begin
      mcnt_d   = '0;
      locked_d = 1'b0;
    end else if (check) begin
      if (word_i != TRAIN_PATTERN) begin
        mcnt_d = '0;
      end else begin
        mcnt_d = mcnt_q + 1'b1;
        if (mcnt_q == MCNT_W'(MATCH_COUNT - 1)) locked_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcnt_q   <= '0;
      locked_q <= 1'b0;
    end else begin
      mcnt_q   <= mcnt_d;
      locked_q <= locked_d;
    end
  end

endmodule

// File: rtl/iddr_deser.sv
// 1:WIDTH deserializer behind an IDDRE1: packs (Q1,Q2) pairs into WIDTH-bit
// words with a bitslip FSM for word alignment.
//   C, R_N : clock (shared with IDDRE1), async active-low reset
//   bus    : iddr_deser_if slave (EN/Q1/Q2/BITSLIP/TRAIN in, DOUT/DVALID/SLIP_BUSY/LOCKED out)
// Optional: define IDDR_DESER_AUTOALIGN_EN to add training-pattern auto-align;
// without it LOCKED is 0 and TRAIN is ignored.
module iddr_deser
  import iddr_deser_pkg::*;
#(
  parameter int               WIDTH         = 8,
  parameter int               SLIP_GUARD    = 4,
  parameter logic [WIDTH-1:0] TRAIN_PATTERN = WIDTH'(8'h5C),
  parameter int               MATCH_COUNT   = 4
) (
  input logic         C,
  input logic         R_N,
  iddr_deser_if.slave bus
);

  localparam int             CNT_W    = (WIDTH / 2 > 1) ? $clog2(WIDTH / 2) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH / 2 - 1);

  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("iddr_deser: WIDTH must be even and within 4..16");
  end

  state_e            state_q, state_d;
  logic [GCNT_W-1:0] gcnt_q, gcnt_d;
  logic              off_q, off_d;
  logic [WIDTH:0]    hist_q, hist_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0]  dout_q, dout_d;
  logic              dvalid_q, dvalid_d;
  logic              hold, boundary, slip_req, ext_slip, auto_slip, locked;

  // Leaving offset 1 pulls the boundary by a whole pair: cnt stalls one cycle.
  assign hold     = (state_q == ST_SLIP) && off_q;
  assign ext_slip = bus.BITSLIP && (state_q == ST_RUN);
  assign slip_req = bus.BITSLIP || auto_slip;

  always_comb begin
    hist_d   = hist_q;
    cnt_d    = cnt_q;
    dout_d   = dout_q;
    boundary = 1'b0;
    if (bus.EN) begin
      hist_d = {hist_q[WIDTH-2:0], bus.Q1, bus.Q2};
      if (!hold) begin
        if (cnt_q == CNT_LAST) begin
          boundary = 1'b1;
          cnt_d    = '0;
          // Offset 1 takes the window one bit older (last bit of previous pair set).
          dout_d   = off_q ? hist_d[WIDTH:1] : hist_d[WIDTH-1:0];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end
    // Blanking keys off the current state so a word coinciding with a slip
    // request in RUN is still delivered.
    dvalid_d = boundary && (state_q == ST_RUN);
  end

  always_comb begin
    state_d = state_q;
    gcnt_d  = gcnt_q;
    off_d   = off_q;
    case (state_q)
      ST_RUN:   if (slip_req) state_d = ST_SLIP;
      ST_SLIP: begin
        off_d   = ~off_q;
        gcnt_d  = GCNT_W'(SLIP_GUARD);
        state_d = ST_GUARD;
      end
      ST_GUARD: begin
        gcnt_d = gcnt_q - 1'b1;
        if (gcnt_q == GCNT_W'(1)) state_d = ST_RUN;
      end
      default:  state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge C or negedge R_N) begin
    if (!R_N) begin
      state_q  <= ST_RUN;
      gcnt_q   <= '0;
      off_q    <= 1'b0;
      hist_q   <= '0;
      cnt_q    <= '0;
      dout_q   <= '0;
      dvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      gcnt_q   <= gcnt_d;
      off_q    <= off_d;
      hist_q   <= hist_d;
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
    end
  end

`ifdef IDDR_DESER_AUTOALIGN_EN
  iddr_deser_align #(
    .WIDTH         (WIDTH),
    .TRAIN_PATTERN (TRAIN_PATTERN),
    .MATCH_COUNT   (MATCH_COUNT)
  ) u_align (
    .clk         (C),
    .rst_n       (R_N),
    .word_stb_i  (dvalid_d),
    .word_i      (dout_d),
    .train_i     (bus.TRAIN),
    .ext_slip_i  (ext_slip),
    .auto_slip_o (auto_slip),
    .locked_o    (locked)
  );
`else
  assign auto_slip = 1'b0;
  assign locked    = 1'b0;
  logic unused_cfg;
  assign unused_cfg = bus.TRAIN ^ ext_slip ^ (^TRAIN_PATTERN) ^ (MATCH_COUNT != 0);
`endif

  assign bus.DOUT      = dout_q;
  assign bus.DVALID    = dvalid_q;
  assign bus.SLIP_BUSY = (state_q != ST_RUN);
  assign bus.LOCKED    = locked;

endmodule

// File: tb/tb_iddr_deser.sv
// Self-checking bench for iddr_deser (WIDTH=8, SLIP_GUARD=4).
// Expected words go into exp_q as the completing pair is driven and are
// popped when DVALID shows up.
module tb_iddr_deser;
  import iddr_deser_pkg::*;

  localparam int W  = 8;
  localparam int SG = 4;

  logic C   = 1'b0;
  logic R_N = 1'b0;

  iddr_deser_if #(.WIDTH(W)) bus ();

  iddr_deser #(
    .WIDTH(W), .SLIP_GUARD(SG), .TRAIN_PATTERN(8'h5C), .MATCH_COUNT(4)
  ) dut (
    .C(C), .R_N(R_N), .bus(bus)
  );

  always #5 C = ~C;

  int           n_cmp = 0;
  int           n_bad = 0;
  int           pidx  = 0;
  logic [W-1:0] pat   = 8'hA5;
  logic [W-1:0] exp_q[$];

  function automatic logic [1:0] pair_of(input int p);
    int ph;
    ph = p % (W / 2);
    return pat[W-1-2*ph -: 2];
  endfunction

  function automatic logic [W-1:0] rotr(input logic [W-1:0] v, input int r);
    logic [2*W-1:0] d;
    d = {v, v};
    return d[r +: W];
  endfunction

  // One clock: drive a pair (and optional slip), sample 1 time unit after the edge.
  task automatic tick(input logic en, input logic sl);
    logic [1:0] pr;
    pr          = pair_of(pidx);
    bus.EN      = en;
    bus.Q1      = pr[1];
    bus.Q2      = pr[0];
    bus.BITSLIP = sl;
    @(posedge C);
    #1;
    if (en) pidx++;
    bus.BITSLIP = 1'b0;
  endtask

  task automatic do_reset();
    R_N = 1'b0;
    bus.EN = 1'b0; bus.Q1 = 1'b0; bus.Q2 = 1'b0; bus.BITSLIP = 1'b0; bus.TRAIN = 1'b0;
    repeat (2) @(posedge C);
    #1;
    R_N  = 1'b1;
    pidx = 0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (bus.DOUT !== '0)     begin n_bad++; $display("FAIL reset_dout got=%h exp=00", bus.DOUT); end
    n_cmp++; if (bus.DVALID !== 1'b0) begin n_bad++; $display("FAIL reset_dvalid got=%b exp=0", bus.DVALID); end
    n_cmp++; if (bus.SLIP_BUSY !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", bus.SLIP_BUSY); end
    n_cmp++; if (bus.LOCKED !== 1'b0) begin n_bad++; $display("FAIL reset_locked got=%b exp=0", bus.LOCKED); end
  endtask

  task automatic test_basic();
    logic [W-1:0] e;
    do_reset();
    pat = 8'hA5;
    for (int i = 0; i < 16; i++) begin
      if (pidx % 4 == 3) exp_q.push_back(8'hA5);
      tick(1'b1, 1'b0);
      n_cmp++;
      if (bus.DVALID !== (exp_q.size() != 0)) begin
        n_bad++; $display("FAIL basic_strobe i=%0d got=%b exp=%b", i, bus.DVALID, exp_q.size() != 0);
      end
      if (bus.DVALID === 1'b1 && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_cmp++; if (bus.DOUT !== e) begin n_bad++; $display("FAIL basic_word got=%h exp=%h", bus.DOUT, e); end
      end
    end
  endtask

  task automatic test_enable();
    logic [W-1:0] e;
    logic         en_seq [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    do_reset();
    pat = 8'hA5;
    for (int i = 0; i < 7; i++) begin
      if (en_seq[i] && pidx % 4 == 3) exp_q.push_back(8'hA5);
      tick(en_seq[i], 1'b0);
      n_cmp++;
      if (bus.DVALID !== (exp_q.size() != 0)) begin
        n_bad++; $display("FAIL enable_strobe i=%0d got=%b exp=%b", i, bus.DVALID, exp_q.size() != 0);
      end
      if (!en_seq[i]) begin
        n_cmp++; if (bus.DOUT !== '0) begin n_bad++; $display("FAIL enable_hold got=%h exp=00", bus.DOUT); end
      end
      if (bus.DVALID === 1'b1 && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_cmp++; if (bus.DOUT !== e) begin n_bad++; $display("FAIL enable_word got=%h exp=%h", bus.DOUT, e); end
      end
    end
  endtask

  task automatic test_single_slip();
    int  bcnt;
    bit  got;
    logic [W-1:0] e;
    do_reset();
    pat = 8'hA5;
    repeat (9) tick(1'b1, 1'b0);   // slip lands on a mid-word pair
    tick(1'b1, 1'b1);
    bcnt = bus.SLIP_BUSY ? 1 : 0;
    exp_q.push_back(8'hD2);
    got = 0;
    for (int t = 0; t < 40 && !got; t++) begin
      tick(1'b1, 1'b0);
      if (bus.SLIP_BUSY) begin
        bcnt++;
        n_cmp++; if (bus.DVALID !== 1'b0) begin n_bad++; $display("FAIL slip_blank got=%b exp=0", bus.DVALID); end
      end else if (bus.DVALID) begin
        e = exp_q.pop_front();
        got = 1;
        n_cmp++; if (bus.DOUT !== e) begin n_bad++; $display("FAIL slip_word got=%h exp=%h", bus.DOUT, e); end
      end
    end
    n_cmp++; if (!got) begin n_bad++; $display("FAIL slip_timeout got=none exp=word"); end
    n_cmp++; if (bcnt != 1 + SG) begin n_bad++; $display("FAIL slip_busy_len got=%0d exp=%0d", bcnt, 1 + SG); end
  endtask

  task automatic test_slip_wrap();
    logic [W-1:0] w, seen;
    int           r_hit;
    bit           got;
    do_reset();
    pat  = 8'hA5;
    seen = '0;
    w    = '0;
    repeat (8) tick(1'b1, 1'b0);
    for (int k = 0; k < W; k++) begin
      tick(1'b1, 1'b1);
      got = 0;
      for (int t = 0; t < 40 && !got; t++) begin
        tick(1'b1, 1'b0);
        if (!bus.SLIP_BUSY && bus.DVALID) begin w = bus.DOUT; got = 1; end
      end
      n_cmp++; if (!got) begin n_bad++; $display("FAIL wrap_timeout k=%0d got=none exp=word", k); end
      r_hit = -1;
      for (int r = 0; r < W; r++) if (rotr(8'hA5, r) == w) r_hit = r;
      n_cmp++;
      if (r_hit < 0 || seen[r_hit]) begin
        n_bad++; $display("FAIL wrap_rotation k=%0d got=%h exp=new rotation of a5", k, w);
      end else seen[r_hit] = 1'b1;
    end
    n_cmp++; if (w !== 8'hA5) begin n_bad++; $display("FAIL wrap_final got=%h exp=a5", w); end
    n_cmp++; if (seen !== '1) begin n_bad++; $display("FAIL wrap_coverage got=%b exp=11111111", seen); end
  endtask

  task automatic test_collision();
    int  bcnt;
    bit  got;
    logic [W-1:0] e;
    do_reset();
    pat = 8'hA5;
    repeat (7) tick(1'b1, 1'b0);
    while (exp_q.size() != 0) void'(exp_q.pop_front());
    exp_q.push_back(8'hA5);        // boundary word must still be delivered
    tick(1'b1, 1'b1);
    e = exp_q.pop_front();
    n_cmp++; if (bus.DVALID !== 1'b1) begin n_bad++; $display("FAIL coll_strobe got=%b exp=1", bus.DVALID); end
    n_cmp++; if (bus.DOUT !== e) begin n_bad++; $display("FAIL coll_word got=%h exp=%h", bus.DOUT, e); end
    bcnt = bus.SLIP_BUSY ? 1 : 0;
    exp_q.push_back(8'hD2);
    got = 0;
    for (int t = 0; t < 40 && !got; t++) begin
      tick(1'b1, t == 1);          // second request lands in GUARD
      if (bus.SLIP_BUSY) bcnt++;
      else if (bus.DVALID) begin
        e = exp_q.pop_front();
        got = 1;
        n_cmp++; if (bus.DOUT !== e) begin n_bad++; $display("FAIL coll_after got=%h exp=%h", bus.DOUT, e); end
      end
    end
    n_cmp++; if (!got) begin n_bad++; $display("FAIL coll_timeout got=none exp=word"); end
    n_cmp++; if (bcnt != 1 + SG) begin n_bad++; $display("FAIL coll_busy_len got=%0d exp=%0d", bcnt, 1 + SG); end
  endtask

  task automatic test_reset_mid_slip();
    logic [W-1:0] e;
    do_reset();
    pat = 8'hA5;
    repeat (9) tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    repeat (2) tick(1'b1, 1'b0);   // now in GUARD with off=1
    #2 R_N = 1'b0;
    #1;
    n_cmp++; if (bus.DOUT !== '0) begin n_bad++; $display("FAIL rst_async_dout got=%h exp=00", bus.DOUT); end
    n_cmp++; if (bus.SLIP_BUSY !== 1'b0) begin n_bad++; $display("FAIL rst_async_busy got=%b exp=0", bus.SLIP_BUSY); end
    n_cmp++; if (bus.DVALID !== 1'b0) begin n_bad++; $display("FAIL rst_async_dvalid got=%b exp=0", bus.DVALID); end
    @(posedge C);
    #1;
    R_N  = 1'b1;
    pidx = 0;
    exp_q.delete();
    for (int i = 0; i < 8; i++) begin
      if (pidx % 4 == 3) exp_q.push_back(8'hA5);
      tick(1'b1, 1'b0);
      n_cmp++;
      if (bus.DVALID !== (exp_q.size() != 0)) begin
        n_bad++; $display("FAIL rst_strobe i=%0d got=%b exp=%b", i, bus.DVALID, exp_q.size() != 0);
      end
      if (bus.DVALID === 1'b1 && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_cmp++; if (bus.DOUT !== e) begin n_bad++; $display("FAIL rst_realign got=%h exp=%h", bus.DOUT, e); end
      end
    end
  endtask

`ifdef IDDR_DESER_AUTOALIGN_EN
  // 0x2E aligned at reset needs three slips to present 0x5C.
  task automatic test_autoalign();
    int slips, matches, busy_after;
    bit prev_busy, locked_seen;
    do_reset();
    pat = 8'h2E;
    bus.TRAIN = 1'b1;
    slips = 0; matches = 0; prev_busy = 0; locked_seen = 0;
    for (int t = 0; t < 400 && !locked_seen; t++) begin
      tick(1'b1, 1'b0);
      if (bus.SLIP_BUSY && !prev_busy) slips++;
      prev_busy = bus.SLIP_BUSY;
      if (bus.DVALID && bus.DOUT == 8'h5C) matches++;
      if (bus.LOCKED) locked_seen = 1;
    end
    n_cmp++; if (!locked_seen) begin n_bad++; $display("FAIL auto_lock_timeout got=0 exp=1"); end
    n_cmp++; if (slips != 3) begin n_bad++; $display("FAIL auto_slips got=%0d exp=3", slips); end
    n_cmp++; if (matches != 4) begin n_bad++; $display("FAIL auto_matches got=%0d exp=4", matches); end
    busy_after = 0;
    repeat (16) begin
      tick(1'b1, 1'b0);
      if (bus.SLIP_BUSY) busy_after++;
    end
    n_cmp++; if (busy_after != 0) begin n_bad++; $display("FAIL auto_post_lock_busy got=%0d exp=0", busy_after); end
    n_cmp++; if (bus.LOCKED !== 1'b1) begin n_bad++; $display("FAIL auto_hold_lock got=%b exp=1", bus.LOCKED); end
    bus.TRAIN = 1'b0;
    tick(1'b1, 1'b1);
    n_cmp++; if (bus.LOCKED !== 1'b0) begin n_bad++; $display("FAIL auto_unlock got=%b exp=0", bus.LOCKED); end
    repeat (8) tick(1'b1, 1'b0);
  endtask
`else
  task automatic test_train_ignored();
    logic [W-1:0] e;
    int           busy_n;
    do_reset();
    pat = 8'h2E;
    bus.TRAIN = 1'b1;
    busy_n = 0;
    for (int i = 0; i < 24; i++) begin
      if (pidx % 4 == 3) exp_q.push_back(8'h2E);
      tick(1'b1, 1'b0);
      if (bus.SLIP_BUSY) busy_n++;
      if (bus.DVALID === 1'b1 && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_cmp++; if (bus.DOUT !== e) begin n_bad++; $display("FAIL train_word got=%h exp=%h", bus.DOUT, e); end
      end
    end
    n_cmp++; if (busy_n != 0) begin n_bad++; $display("FAIL train_no_slip got=%0d exp=0", busy_n); end
    n_cmp++; if (bus.LOCKED !== 1'b0) begin n_bad++; $display("FAIL train_locked got=%b exp=0", bus.LOCKED); end
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL train_pending got=%0d exp=0", exp_q.size()); end
    bus.TRAIN = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_enable();
    test_single_slip();
    test_slip_wrap();
    test_collision();
    test_reset_mid_slip();
`ifdef IDDR_DESER_AUTOALIGN_EN
    test_autoalign();
`else
    test_train_ignored();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1);
  end

endmodule
